// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: sequencer state codes and instruction field positions.
package hack_pkg;

    // Sequencer states, kept as plain constants so legacy code can compare encodings.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMWR  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    // Instruction field bit positions (Hack encoding).
    localparam int C_BIT   = 15;
    localparam int D_M_BIT = 3;
    localparam int J_LT    = 2;
    localparam int J_EQ    = 1;
    localparam int J_GT    = 0;

    // A C-instruction with the M destination bit set writes data memory.
    function automatic logic is_mem_write(input logic [15:0] ins);
        return ins[C_BIT] & ins[D_M_BIT];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ROM fetch and data-memory write handshakes between the sequencer and memories.
interface pc_sequencer_if #(
    parameter int IW = 16
);
    logic          rom_req;
    logic          rom_ack;
    logic [IW-1:0] rom_data;
    logic          mem_wr_req;
    logic          mem_wr_ack;

    modport master (
        output rom_req,
        input  rom_ack,
        input  rom_data,
        output mem_wr_req,
        input  mem_wr_ack
    );

    modport slave (
        input  rom_req,
        output rom_ack,
        output rom_data,
        input  mem_wr_req,
        output mem_wr_ack
    );
endinterface

// File: rtl/jump_cond.sv
// Combinational Hack jump decode: j bits select which ALU result signs jump.
module jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // Less-than, equal and greater-than map directly onto ng, zr and neither.
    assign take = (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for the Hack CPU: fetches an instruction, gives it
// one execute cycle, completes any memory write, then issues one PC update.
module pc_sequencer
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    pc_sequencer_if.master   bus,
    output logic [IW-1:0]    instr,
    output logic             instr_valid,
    input  logic             alu_zr,
    input  logic             alu_ng,
    input  logic [WIDTH-1:0] a_value,
    input  logic [WIDTH-1:0] pc_value,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             pc_reset,
    output logic             halted,
    output logic [WIDTH-1:0] instr_count
);

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    instr_q, instr_d;
    logic             take_q, take_d;
    logic             self_q, self_d;
    logic             halted_q, halted_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pc_reset_q;
    logic             reset_seen_q;
    logic             jc_take_s;

    jump_cond u_jump_cond (
        .j    (instr_q[J_LT:J_GT]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (jc_take_s)
    );

    // Next-state and datapath-register logic; acks only matter in their own state.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        take_d   = take_q;
        self_d   = self_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (run && !pc_reset_q) state_d = S_FETCH;
                else                    state_d = S_IDLE;
            end
            S_FETCH: begin
                if (bus.rom_ack) begin
                    instr_d = bus.rom_data;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                // Flags are only valid now, so the jump decision is captured here.
                take_d = instr_q[C_BIT] & jc_take_s;
                self_d = instr_q[C_BIT] & jc_take_s & (a_value == pc_value);
                if (is_mem_write(instr_q)) state_d = S_MEMWR;
                else                       state_d = S_UPDATE;
            end
            S_MEMWR: begin
                if (bus.mem_wr_ack) state_d = S_UPDATE;
                else                state_d = S_MEMWR;
            end
            S_UPDATE: begin
                count_d = count_q + WIDTH'(1);
                if (self_q) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset dominates and stretches pc_reset one cycle past release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            take_q       <= 1'b0;
            self_q       <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
            pc_reset_q   <= 1'b1;
            reset_seen_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            take_q       <= take_d;
            self_q       <= self_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
            pc_reset_q   <= reset_seen_q;
            reset_seen_q <= 1'b0;
        end
    end

    // Every output comes from a register or from the registered state alone.
    assign bus.rom_req    = (state_q == S_FETCH);
    assign bus.mem_wr_req = (state_q == S_MEMWR);
    assign instr_valid    = (state_q == S_EXEC);
    assign pc_load        = (state_q == S_UPDATE) & take_q;
    assign pc_inc         = (state_q == S_UPDATE) & ~take_q;
    assign pc_reset       = pc_reset_q;
    assign halted         = halted_q;
    assign instr          = instr_q;
    assign instr_count    = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random instructions
// checked against a transaction-level model of the fetch/exec/write/update rules.
module tb_pc_sequencer;
    localparam int WIDTH = 16;
    localparam int IW    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [IW-1:0]    instr;
    logic             instr_valid;
    logic             alu_zr, alu_ng;
    logic [WIDTH-1:0] a_value, pc_value;
    logic             pc_load, pc_inc, pc_reset, halted;
    logic [WIDTH-1:0] instr_count;

    int          errors = 0;
    int          checks = 0;
    int unsigned m_count = 0;
    bit          m_halted = 1'b0;

    pc_sequencer_if #(.IW(IW)) bus ();

    pc_sequencer #(.WIDTH(WIDTH), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .bus         (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .a_value     (a_value),
        .pc_value    (pc_value),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .pc_reset    (pc_reset),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven just after each falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic restart(input bit run_val);
        reset = 1'b1; run = run_val; bus.rom_ack = 1'b0; bus.mem_wr_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        m_count = 0; m_halted = 1'b0;
    endtask

    // One full instruction: fetch with rdly wait cycles, execute, optional write, update.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] pc,
                             input bit zr, input bit ng, input int rdly, input int mdly,
                             input bit run_at_exec);
        int to = 0;
        bit exp_take, exp_wr, exp_self;
        while (bus.rom_req !== 1'b1 && to < 20) begin step(); to++; end
        checks++;
        if (bus.rom_req !== 1'b1) begin
            errors++; $display("FAIL fetch_timeout rom_req=%b expected 1", bus.rom_req); return;
        end
        for (int i = 0; i <= rdly; i++) begin
            checks++;
            if (bus.rom_req !== 1'b1 || pc_load !== 1'b0 || pc_inc !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold rom_req=%b load=%b inc=%b expected 1/0/0", bus.rom_req, pc_load, pc_inc);
            end
            bus.rom_ack    = (i == rdly);
            bus.rom_data   = (i == rdly) ? ins : 16'($urandom);
            bus.mem_wr_ack = 1'($urandom);
            step();
        end
        bus.mem_wr_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== ins || bus.rom_req !== 1'b0) begin
            errors++;
            $display("FAIL exec valid=%b instr=%h rom_req=%b expected 1/%h/0", instr_valid, instr, bus.rom_req, ins);
        end
        alu_zr = zr; alu_ng = ng; a_value = a; pc_value = pc; run = run_at_exec;
        bus.rom_ack = 1'($urandom); bus.rom_data = 16'($urandom);
        exp_take = ins[15] && ((ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr));
        exp_wr   = ins[15] && ins[3];
        exp_self = exp_take && (a == pc);
        step();
        bus.rom_ack = 1'b0;
        alu_zr = 1'($urandom); alu_ng = 1'($urandom); a_value = 16'($urandom); pc_value = 16'($urandom);
        if (exp_wr) begin
            for (int i = 0; i <= mdly; i++) begin
                checks++;
                if (bus.mem_wr_req !== 1'b1 || pc_load !== 1'b0 || pc_inc !== 1'b0) begin
                    errors++;
                    $display("FAIL memwr_hold mem_wr_req=%b load=%b inc=%b expected 1/0/0", bus.mem_wr_req, pc_load, pc_inc);
                end
                bus.mem_wr_ack = (i == mdly);
                step();
            end
            bus.mem_wr_ack = 1'b0;
        end
        checks++;
        if (pc_load !== exp_take || pc_inc !== !exp_take || bus.mem_wr_req !== 1'b0 || instr !== ins) begin
            errors++;
            $display("FAIL update load=%b inc=%b mem_wr_req=%b instr=%h expected %b/%b/0/%h",
                     pc_load, pc_inc, bus.mem_wr_req, instr, exp_take, !exp_take, ins);
        end
        step();
        m_count = (m_count + 1) % 65536;
        if (exp_self) m_halted = 1'b1;
        checks++;
        if (instr_count !== 16'(m_count) || halted !== m_halted || pc_load !== 1'b0 || pc_inc !== 1'b0
            || bus.rom_req !== (run_at_exec && !exp_self)) begin
            errors++;
            $display("FAIL retire count=%0d halted=%b load=%b inc=%b rom_req=%b expected %0d/%b/0/0/%b",
                     instr_count, halted, pc_load, pc_inc, bus.rom_req, m_count, m_halted, run_at_exec && !exp_self);
        end
    endtask

    // A halted sequencer must stay quiet until reset.
    task automatic check_quiet(input string name, input int n, input bit exp_halted);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bus.rom_req !== 1'b0 || bus.mem_wr_req !== 1'b0 || pc_load !== 1'b0 || pc_inc !== 1'b0
                || halted !== exp_halted) begin
                errors++;
                $display("FAIL %s rom_req=%b mem_wr_req=%b load=%b inc=%b halted=%b expected 0/0/0/0/%b",
                         name, bus.rom_req, bus.mem_wr_req, pc_load, pc_inc, halted, exp_halted);
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; bus.rom_ack = 1'b0; bus.mem_wr_ack = 1'b0; bus.rom_data = '0;
        alu_zr = 1'b0; alu_ng = 1'b0; a_value = '0; pc_value = '0;
        step(); step(); step();
        checks++;
        if (pc_reset !== 1'b1 || bus.rom_req !== 1'b0 || bus.mem_wr_req !== 1'b0 || pc_load !== 1'b0
            || pc_inc !== 1'b0 || instr !== 16'h0000 || instr_count !== 16'h0000 || halted !== 1'b0
            || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc_reset=%b rom_req=%b instr=%h count=%0d halted=%b expected 1/0/0000/0/0",
                     pc_reset, bus.rom_req, instr, instr_count, halted);
        end
        reset = 1'b0; m_count = 0; m_halted = 1'b0;
        step();
        checks++;
        if (pc_reset !== 1'b1) begin errors++; $display("FAIL pc_reset_stretch pc_reset=%b expected 1", pc_reset); end
        step();
        checks++;
        if (pc_reset !== 1'b0) begin errors++; $display("FAIL pc_reset_release pc_reset=%b expected 0", pc_reset); end
        check_quiet("idle_run0", 3, 1'b0);
    endtask

    task automatic test_first_fetch();
        restart(1'b1);
        step();
        checks++;
        if (pc_reset !== 1'b1 || bus.rom_req !== 1'b0) begin
            errors++; $display("FAIL start_n1 pc_reset=%b rom_req=%b expected 1/0", pc_reset, bus.rom_req);
        end
        step();
        checks++;
        if (pc_reset !== 1'b0 || bus.rom_req !== 1'b0) begin
            errors++; $display("FAIL start_n2 pc_reset=%b rom_req=%b expected 0/0", pc_reset, bus.rom_req);
        end
        step();
        checks++;
        if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL start_fetch rom_req=%b expected 1", bus.rom_req); end
        run_instr(16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_jumps();
        run_instr(16'hE307, 16'h0010, 16'h0003, 1'b0, 1'b0, 1, 0, 1'b1);
        run_instr(16'hE302, 16'h0020, 16'h0004, 1'b0, 1'b1, 0, 0, 1'b1);
        run_instr(16'hE302, 16'h0020, 16'h0005, 1'b1, 1'b0, 2, 0, 1'b1);
        run_instr(16'h8008, 16'h0007, 16'h0007, 1'b1, 1'b1, 0, 0, 1'b1);
    endtask

    task automatic test_mem_write();
        run_instr(16'hEC08, 16'h0100, 16'h0006, 1'b0, 1'b0, 0, 3, 1'b1);
    endtask

    task automatic test_halt();
        run_instr(16'hE307, 16'h0007, 16'h0007, 1'b0, 1'b1, 0, 0, 1'b1);
        check_quiet("halt_quiet", 6, 1'b1);
        restart(1'b0);
        step();
        checks++;
        if (halted !== 1'b0 || instr_count !== 16'h0000) begin
            errors++; $display("FAIL halt_clear halted=%b count=%0d expected 0/0", halted, instr_count);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int to = 0;
        restart(1'b1);
        while (bus.rom_req !== 1'b1 && to < 20) begin step(); to++; end
        reset = 1'b1; bus.rom_ack = 1'b1; bus.rom_data = 16'hFFFF;
        step();
        checks++;
        if (bus.rom_req !== 1'b0 || instr !== 16'h0000 || pc_reset !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch rom_req=%b instr=%h pc_reset=%b expected 0/0000/1", bus.rom_req, instr, pc_reset);
        end
        reset = 1'b0; run = 1'b0; m_count = 0; m_halted = 1'b0;
        step();
        bus.rom_ack = 1'b0;
        check_quiet("late_ack", 4, 1'b0);
        run = 1'b1;
        run_instr(16'hE302, 16'h0011, 16'h0001, 1'b1, 1'b0, 0, 0, 1'b0);
        check_quiet("run0_idle", 4, 1'b0);
        run = 1'b1;
        step();
        checks++;
        if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL resume rom_req=%b expected 1", bus.rom_req); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [15:0] ins, a, pc;
            ins = 16'($urandom);
            if (($urandom % 4) != 0) ins[15] = 1'b1;
            a  = 16'($urandom);
            pc = (($urandom % 5) == 0) ? a : 16'($urandom);
            run_instr(ins, a, pc, 1'($urandom), 1'($urandom), int'($urandom % 3), int'($urandom % 3), 1'b1);
            if (m_halted) begin
                check_quiet("rand_halt", 3, 1'b1);
                restart(1'b1);
            end
        end
    endtask

    // Hard bound on the whole run in case the design stops responding.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rom_ack = 1'b0; bus.mem_wr_ack = 1'b0; bus.rom_data = '0;
        reset = 1'b1; run = 1'b0;
        test_reset();
        test_first_fetch();
        test_jumps();
        test_mem_write();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
